// File: rtl/ndf_seq_if.sv
// Serial-link and NAND-pin bundle for the NAND-flash byte sequencer.
// master = sequencer side, slave = UART/NAND side.
interface ndf_seq_if;
    logic       rx_strobe;
    logic [7:0] rx_data;
    logic       tx_strobe;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       ndf_r_b_n;
    logic       ndf_ce_n;
    logic       ndf_cle;
    logic       ndf_ale;
    logic       ndf_we_n;
    logic       ndf_re_n;
    logic       ndf_wp_n;
    logic [7:0] ndf_io_o;
    logic       ndf_io_oe;
    logic [7:0] ndf_io_i;

    modport master (
        input  rx_strobe, rx_data, tx_busy,
        input  ndf_r_b_n, ndf_io_i,
        output tx_strobe, tx_data,
        output ndf_ce_n, ndf_cle, ndf_ale,
        output ndf_we_n, ndf_re_n, ndf_wp_n,
        output ndf_io_o, ndf_io_oe
    );

    modport slave (
        output rx_strobe, rx_data, tx_busy,
        output ndf_r_b_n, ndf_io_i,
        input  tx_strobe, tx_data,
        input  ndf_ce_n, ndf_cle, ndf_ale,
        input  ndf_we_n, ndf_re_n, ndf_wp_n,
        input  ndf_io_o, ndf_io_oe
    );
endinterface

// File: rtl/ndf_seq.sv
// NAND-flash byte sequencer: decodes host letters from the serial
// link and drives CLE/ALE/WE#/RE# cycles with programmable wait states.
module ndf_seq #(
    parameter int TWP     = 2,
    parameter int TWH     = 2,
    parameter int TREA    = 2,
    parameter int TREH    = 1,
    parameter int BUSY_TO = 100000,
    parameter int CW      = 17
) (
    input  logic       clk10,
    input  logic       rst,
    ndf_seq_if.master  bus,
    output logic [7:0] state_dbg
);
    typedef enum logic [7:0] {
        S_IDLE  = 8'h00,
        S_ARG   = 8'h01,
        S_WR_LO = 8'h02,
        S_WR_HI = 8'h03,
        S_RD_LO = 8'h04,
        S_RD_HI = 8'h05,
        S_BUSY  = 8'h06,
        S_SEND  = 8'h07,
        S_TX_HI = 8'h08,
        S_TX_LO = 8'h09
    } state_t;

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] TWP_E  = CW'(TWP - 1);
    localparam logic [CW-1:0] TWH_E  = CW'(TWH - 1);
    localparam logic [CW-1:0] TREA_E = CW'(TREA - 1);
    localparam logic [CW-1:0] TREH_E = CW'(TREH - 1);
    localparam logic [CW-1:0] BTO_E  = CW'(BUSY_TO - 1);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    nbyte_q, nbyte_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_strobe_q, tx_strobe_d;
    logic [7:0]    io_o_q, io_o_d;
    logic          wp_n_q, wp_n_d;
    logic          cle_q, cle_d;
    logic          ale_q, ale_d;
    logic          we_n_q, we_n_d;
    logic          re_n_q, re_n_d;
    logic          io_oe_q, io_oe_d;
    logic          ce_n_q;

    // Next state; pin outputs are derived from the next state so they
    // line up exactly with the registered state code.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        nbyte_d     = nbyte_q;
        tx_data_d   = tx_data_q;
        io_o_d      = io_o_q;
        wp_n_d      = wp_n_q;
        tx_strobe_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.rx_strobe) begin
                    cmd_d = bus.rx_data;
                    case (bus.rx_data)
                        "P": begin
                            tx_data_d = "A";
                            state_d   = S_SEND;
                        end
                        "C", "A", "R", "W": state_d = S_ARG;
                        "B": begin
                            cnt_d = '0;
                            if (bus.ndf_r_b_n) begin
                                tx_data_d = "A";
                                state_d   = S_SEND;
                            end else begin
                                state_d = S_BUSY;
                            end
                        end
                        default: begin
                            tx_data_d = "?";
                            state_d   = S_SEND;
                        end
                    endcase
                end
            end
            S_ARG: begin
                if (bus.rx_strobe) begin
                    cnt_d = '0;
                    if (cmd_q == "R") begin
                        nbyte_d = bus.rx_data;
                        state_d = S_RD_LO;
                    end else if (cmd_q == "W") begin
                        wp_n_d    = bus.rx_data[0];
                        tx_data_d = "A";
                        state_d   = S_SEND;
                    end else begin
                        io_o_d  = bus.rx_data;
                        state_d = S_WR_LO;
                    end
                end
            end
            S_WR_LO: begin
                if (cnt_q == TWP_E) begin
                    cnt_d   = '0;
                    state_d = S_WR_HI;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_WR_HI: begin
                if (cnt_q == TWH_E) begin
                    tx_data_d = "A";
                    state_d   = S_SEND;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_RD_LO: begin
                if (cnt_q == TREA_E) begin
                    tx_data_d = bus.ndf_io_i;
                    nbyte_d   = nbyte_q - 8'd1;
                    state_d   = S_SEND;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_RD_HI: begin
                if (cnt_q == TREH_E) begin
                    cnt_d   = '0;
                    state_d = (nbyte_q == 8'd0) ? S_IDLE : S_RD_LO;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_BUSY: begin
                if (bus.ndf_r_b_n) begin
                    tx_data_d = "A";
                    state_d   = S_SEND;
                end else if (cnt_q == BTO_E) begin
                    tx_data_d = "T";
                    state_d   = S_SEND;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_SEND: begin
                if (!bus.tx_busy) begin
                    tx_strobe_d = 1'b1;
                    state_d     = S_TX_HI;
                end
            end
            S_TX_HI: begin
                if (bus.tx_busy) state_d = S_TX_LO;
            end
            S_TX_LO: begin
                if (!bus.tx_busy) begin
                    cnt_d   = '0;
                    state_d = (cmd_q == "R") ? S_RD_HI : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        io_oe_d = (state_d == S_WR_LO) || (state_d == S_WR_HI);
        we_n_d  = (state_d != S_WR_LO);
        re_n_d  = (state_d != S_RD_LO);
        cle_d   = io_oe_d && (cmd_d == "C");
        ale_d   = io_oe_d && (cmd_d == "A");
    end

    // State and registered pin/link outputs; reset aborts any operation.
    always_ff @(posedge clk10) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            nbyte_q     <= '0;
            tx_data_q   <= '0;
            tx_strobe_q <= 1'b0;
            io_o_q      <= '0;
            wp_n_q      <= 1'b0;
            cle_q       <= 1'b0;
            ale_q       <= 1'b0;
            we_n_q      <= 1'b1;
            re_n_q      <= 1'b1;
            io_oe_q     <= 1'b0;
            ce_n_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            nbyte_q     <= nbyte_d;
            tx_data_q   <= tx_data_d;
            tx_strobe_q <= tx_strobe_d;
            io_o_q      <= io_o_d;
            wp_n_q      <= wp_n_d;
            cle_q       <= cle_d;
            ale_q       <= ale_d;
            we_n_q      <= we_n_d;
            re_n_q      <= re_n_d;
            io_oe_q     <= io_oe_d;
            ce_n_q      <= 1'b0;
        end
    end

    assign bus.tx_strobe = tx_strobe_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.ndf_ce_n  = ce_n_q;
    assign bus.ndf_cle   = cle_q;
    assign bus.ndf_ale   = ale_q;
    assign bus.ndf_we_n  = we_n_q;
    assign bus.ndf_re_n  = re_n_q;
    assign bus.ndf_wp_n  = wp_n_q;
    assign bus.ndf_io_o  = io_o_q;
    assign bus.ndf_io_oe = io_oe_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_ndf_seq.sv
// Directed bench for ndf_seq: scoreboard of expected tx bytes,
// UART transmitter model and NAND read-data/pulse-timing monitor.
module tb_ndf_seq;
    localparam int TWP     = 2;
    localparam int TWH     = 2;
    localparam int TREA    = 2;
    localparam int TREH    = 1;
    localparam int BUSY_TO = 20;

    logic       clk10 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] state_dbg;
    logic       rx_strobe = 1'b0;
    logic [7:0] rx_data = '0;
    logic       tx_busy = 1'b0;
    logic       r_b_n = 1'b1;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int busy_len = 3;
    int busy_cnt = 0;
    int re_pulses = 0;
    int re_run = 0;
    int we_run = 0;
    int we_total = 0;
    int last_we_len = 0;
    int cle_run = 0;
    int last_cle_len = 0;
    int ale_run = 0;
    int last_ale_len = 0;
    int cle_io_bad = 0;
    int n_strobe = 0;
    int strobe_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    ndf_seq_if bus();

    assign bus.rx_strobe = rx_strobe;
    assign bus.rx_data   = rx_data;
    assign bus.tx_busy   = tx_busy;
    assign bus.ndf_r_b_n = r_b_n;
    assign bus.ndf_io_i  = 8'((re_pulses + 1) * 17);

    ndf_seq #(
        .TWP(TWP), .TWH(TWH), .TREA(TREA), .TREH(TREH),
        .BUSY_TO(BUSY_TO), .CW(17)
    ) dut (
        .clk10(clk10),
        .rst(rst),
        .bus(bus.master),
        .state_dbg(state_dbg)
    );

    always #5 clk10 = ~clk10;

    always @(posedge clk10) cyc++;

    // Transmitter model, scoreboard pop and NAND pin monitor.
    always @(negedge clk10) begin
        if (!rst) begin
            checks++;
            assert (!(bus.ndf_io_oe && !bus.ndf_re_n)) else begin
                errs++;
                $error("FAIL oe_re_overlap got oe=%b re_n=%b exp no overlap",
                       bus.ndf_io_oe, bus.ndf_re_n);
            end
            if (tx_busy) begin
                checks++;
                assert (bus.ndf_re_n === 1'b1) else begin
                    errs++;
                    $error("FAIL re_stall got re_n=%b exp 1", bus.ndf_re_n);
                end
            end
            if (bus.tx_strobe) begin
                n_strobe++;
                strobe_cyc = cyc;
                checks++;
                assert (!tx_busy) else begin
                    errs++;
                    $error("FAIL strobe_busy got busy=1 exp 0");
                end
                checks++;
                assert (exp_q.size() != 0) else begin
                    errs++;
                    $error("FAIL tx_extra got=%h exp none", bus.tx_data);
                end
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    checks++;
                    assert (bus.tx_data === exp_b) else begin
                        errs++;
                        $error("FAIL tx_data got=%h exp=%h", bus.tx_data, exp_b);
                    end
                end
                tx_busy = 1'b1;
                busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (!bus.ndf_re_n) begin
                re_run++;
            end else if (re_run > 0) begin
                checks++;
                assert (re_run == TREA) else begin
                    errs++;
                    $error("FAIL re_len got=%0d exp=%0d", re_run, TREA);
                end
                re_pulses++;
                re_run = 0;
            end
            if (!bus.ndf_we_n) begin
                we_run++;
            end else if (we_run > 0) begin
                last_we_len = we_run;
                we_total += we_run;
                we_run = 0;
            end
            if (bus.ndf_cle) begin
                cle_run++;
                if (bus.ndf_io_o !== 8'hFF || !bus.ndf_io_oe) cle_io_bad++;
            end else if (cle_run > 0) begin
                last_cle_len = cle_run;
                cle_run = 0;
            end
            if (bus.ndf_ale) begin
                ale_run++;
            end else if (ale_run > 0) begin
                last_ale_len = ale_run;
                ale_run = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_strobe = 1'b1;
        @(negedge clk10);
        rx_strobe = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk10);
            n++;
        end while (!(exp_q.size() == 0 && !tx_busy && state_dbg == 8'h00)
                   && n < budget);
        checks++;
        assert (n < budget) else begin
            errs++;
            $error("FAIL %s_timeout got=%0d cycles exp <%0d", tag, n, budget);
        end
    endtask

    initial begin
        int s0;
        int w0;
        int r0;
        int n;
        repeat (3) @(negedge clk10);
        chk("rst_ce_n", 32'(bus.ndf_ce_n), 0);
        chk("rst_cle", 32'(bus.ndf_cle), 0);
        chk("rst_ale", 32'(bus.ndf_ale), 0);
        chk("rst_we_n", 32'(bus.ndf_we_n), 1);
        chk("rst_re_n", 32'(bus.ndf_re_n), 1);
        chk("rst_wp_n", 32'(bus.ndf_wp_n), 0);
        chk("rst_io_oe", 32'(bus.ndf_io_oe), 0);
        chk("rst_io_o", 32'(bus.ndf_io_o), 0);
        chk("rst_tx_strobe", 32'(bus.tx_strobe), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_state", 32'(state_dbg), 0);
        rst = 1'b0;
        @(negedge clk10);

        w0 = we_total;
        r0 = re_pulses;
        s0 = n_strobe;
        exp_q.push_back("A");
        send("P");
        wait_done("ping", 100);
        chk("ping_strobes", 32'(n_strobe - s0), 1);
        chk("ping_we", 32'(we_total - w0), 0);
        chk("ping_re", 32'(re_pulses - r0), 0);

        cle_io_bad = 0;
        exp_q.push_back("A");
        send("C");
        send(8'hFF);
        wait_done("cle", 100);
        chk("cle_we_len", 32'(last_we_len), TWP);
        chk("cle_len", 32'(last_cle_len), TWP + TWH);
        chk("cle_io", 32'(cle_io_bad), 0);

        exp_q.push_back("A");
        send("A");
        send(8'h5A);
        wait_done("ale", 100);
        chk("ale_len", 32'(last_ale_len), TWP + TWH);
        chk("ale_io_o", 32'(bus.ndf_io_o), 32'h5A);

        re_pulses = 0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        send("R");
        send(8'h03);
        wait_done("rd3", 300);
        chk("rd3_pulses", 32'(re_pulses), 3);

        busy_len = 50;
        re_pulses = 0;
        for (int i = 0; i < 256; i++) exp_q.push_back(8'((i + 1) * 17));
        send("R");
        send(8'h00);
        wait_done("rd256", 30000);
        chk("rd256_pulses", 32'(re_pulses), 256);
        busy_len = 3;

        r_b_n = 1'b0;
        exp_q.push_back("T");
        send("B");
        s0 = cyc;
        wait_done("bto", 200);
        chk("bto_latency", 32'(strobe_cyc - s0), BUSY_TO + 1);

        exp_q.push_back("A");
        send("B");
        s0 = cyc;
        repeat (5) @(negedge clk10);
        r_b_n = 1'b1;
        wait_done("brdy", 200);
        chk("brdy_latency", 32'(strobe_cyc - s0), 7);

        exp_q.push_back("A");
        send("B");
        s0 = cyc;
        wait_done("bnow", 100);
        chk("bnow_latency", 32'(strobe_cyc - s0), 1);

        exp_q.push_back("?");
        send("Z");
        wait_done("unk", 100);

        exp_q.push_back("A");
        send("W");
        send(8'h01);
        wait_done("wp", 100);
        chk("wp_n_set", 32'(bus.ndf_wp_n), 1);

        send("C");
        send(8'h42);
        n = 0;
        while (bus.ndf_we_n && n < 20) begin
            @(negedge clk10);
            n++;
        end
        chk("wrlo_reached", 32'(bus.ndf_we_n), 0);
        rst = 1'b1;
        @(negedge clk10);
        chk("abort_we_n", 32'(bus.ndf_we_n), 1);
        chk("abort_io_oe", 32'(bus.ndf_io_oe), 0);
        chk("abort_wp_n", 32'(bus.ndf_wp_n), 0);
        chk("abort_cle", 32'(bus.ndf_cle), 0);
        chk("abort_state", 32'(state_dbg), 0);
        chk("abort_strobe", 32'(bus.tx_strobe), 0);
        rst = 1'b0;
        we_run = 0;
        cle_run = 0;
        @(negedge clk10);

        exp_q.push_back("A");
        send("P");
        wait_done("ping2", 100);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
